// File: rtl/difftest_commit_queue.sv
`default_nettype none
// ============================================================================
// Module      : difftest_commit_queue
// Description : Multi-lane commit record queue for difftest. Each cycle up to
//               CHANNELS commit lanes are compacted (ascending lane order,
//               lane 0 oldest) into a circular buffer and drained one record
//               per cycle through a valid/ready head port. A group arriving
//               when fewer than CHANNELS entries are free is dropped whole
//               and counted. An ebreak record blocks further enqueue; its
//               dequeue raises halted.
// Ports       : clock, reset (async, active low)
//               commit_valid/commit_pc/commit_debug_pc/commit_flags (lanes in)
//               in_ready, out_valid/out_ready, out_pc/out_debug_pc/out_flags
//               halted, overflow, drop_cnt
//               out_timestamp (only with DIFFTEST_TIMESTAMP_EN)
// Options     : `define DIFFTEST_TIMESTAMP_EN adds a 64-bit cycle stamp per
//               record and the out_timestamp port.
// Revision    : 1.0 - initial release
// ============================================================================
module difftest_commit_queue #(
    parameter int DATA_W   = 64,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          commit_valid,
    input  logic [CHANNELS*DATA_W-1:0]   commit_pc,
    input  logic [CHANNELS*DATA_W-1:0]   commit_debug_pc,
    input  logic [CHANNELS*3-1:0]        commit_flags,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_pc,
    output logic [DATA_W-1:0]            out_debug_pc,
    output logic [2:0]                   out_flags,
    output logic                         halted,
    output logic                         overflow,
`ifdef DIFFTEST_TIMESTAMP_EN
    output logic [63:0]                  out_timestamp,
`endif
    output logic [15:0]                  drop_cnt
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;
    localparam int c_LCNT_W = $clog2(CHANNELS + 1);
    localparam int c_EBREAK = 2;   // flag bit position of ebreak

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic                r_blocked;
    logic                r_halted;
    logic                r_overflow;
    logic [15:0]         r_drop_cnt;

    logic [DATA_W-1:0]   r_mem_pc    [DEPTH];
    logic [DATA_W-1:0]   r_mem_dpc   [DEPTH];
    logic [2:0]          r_mem_flags [DEPTH];

    // ------------------------------------------------------------------
    // Occupancy
    // ------------------------------------------------------------------
    logic [c_PTR_W-1:0]  w_count;
    logic [c_PTR_W-1:0]  w_free;
    logic                w_full;
    logic                w_empty;
    logic [c_ADDR_W-1:0] w_rd_addr;
    logic                w_pop;

    // Pointer difference modulo 2*DEPTH yields 0..DEPTH directly.
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_free    = c_PTR_W'(DEPTH) - w_count;
    assign w_full    = (r_wr_ptr[c_PTR_W-1] != r_rd_ptr[c_PTR_W-1]) &&
                       (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_rd_addr = r_rd_ptr[c_ADDR_W-1:0];

    // reset gates in_ready so nothing is offered while reset is held low.
    assign in_ready  = reset && !r_blocked && !w_full &&
                       (w_free >= c_PTR_W'(CHANNELS));
    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;

    assign out_pc       = r_mem_pc[w_rd_addr];
    assign out_debug_pc = r_mem_dpc[w_rd_addr];
    assign out_flags    = r_mem_flags[w_rd_addr];
    assign halted       = r_halted;
    assign overflow     = r_overflow;
    assign drop_cnt     = r_drop_cnt;

    // ------------------------------------------------------------------
    // Lane compaction: each accepted lane gets the next free slot after
    // the lanes below it. An ebreak lane closes the group; higher lanes
    // are silently discarded.
    // ------------------------------------------------------------------
    logic                w_accept;
    logic [c_PTR_W-1:0]  w_push_cnt;
    logic                w_stop;
    logic [CHANNELS-1:0] w_lane_we;
    logic [c_ADDR_W-1:0] w_lane_addr [CHANNELS];

    assign w_accept = in_ready && (|commit_valid);

    always_comb begin
        w_push_cnt = '0;
        w_stop     = 1'b0;
        w_lane_we  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_lane_addr[i] = '0;
            if (w_accept && commit_valid[i] && !w_stop) begin
                w_lane_we[i]   = 1'b1;
                w_lane_addr[i] = r_wr_ptr[c_ADDR_W-1:0] + w_push_cnt[c_ADDR_W-1:0];
                w_push_cnt     = w_push_cnt + 1'b1;
                if (commit_flags[i*3 + c_EBREAK]) begin
                    w_stop = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Drop accounting
    // ------------------------------------------------------------------
    logic                w_drop;
    logic [c_LCNT_W-1:0] w_valid_cnt;
    logic [16:0]         w_drop_sum;

    assign w_drop = (|commit_valid) && !in_ready;

    always_comb begin
        w_valid_cnt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_valid_cnt = w_valid_cnt + c_LCNT_W'(commit_valid[i]);
        end
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_valid_cnt);

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_blocked  <= 1'b0;
            r_halted   <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_push_cnt;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (r_mem_flags[w_rd_addr][c_EBREAK]) begin
                    r_halted <= 1'b1;
                end
            end
            if (w_stop) begin
                r_blocked <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Record storage (no reset needed; contents are gated by out_valid)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_lane_we[i]) begin
                r_mem_pc[w_lane_addr[i]]    <= commit_pc[i*DATA_W +: DATA_W];
                r_mem_dpc[w_lane_addr[i]]   <= commit_debug_pc[i*DATA_W +: DATA_W];
                r_mem_flags[w_lane_addr[i]] <= commit_flags[i*3 +: 3];
            end
        end
    end

`ifdef DIFFTEST_TIMESTAMP_EN
    // ------------------------------------------------------------------
    // Free-running cycle stamp stored alongside each record
    // ------------------------------------------------------------------
    logic [63:0] r_cycle;
    logic [63:0] r_mem_ts [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_lane_we[i]) begin
                r_mem_ts[w_lane_addr[i]] <= r_cycle;
            end
        end
    end

    assign out_timestamp = r_mem_ts[w_rd_addr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_difftest_commit_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_difftest_commit_queue
// Description : Directed self-checking bench for difftest_commit_queue with
//               CHANNELS=2, DEPTH=8, DATA_W=64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_difftest_commit_queue;

    localparam int c_DATA_W = 64;
    localparam int c_CH     = 2;
    localparam int c_DEPTH  = 8;

    logic                       clock;
    logic                       reset;
    logic [c_CH-1:0]            commit_valid;
    logic [c_CH*c_DATA_W-1:0]   commit_pc;
    logic [c_CH*c_DATA_W-1:0]   commit_debug_pc;
    logic [c_CH*3-1:0]          commit_flags;
    logic                       in_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic [c_DATA_W-1:0]        out_pc;
    logic [c_DATA_W-1:0]        out_debug_pc;
    logic [2:0]                 out_flags;
    logic                       halted;
    logic                       overflow;
    logic [15:0]                drop_cnt;
`ifdef DIFFTEST_TIMESTAMP_EN
    logic [63:0]                out_timestamp;
`endif

    int n_total  = 0;
    int n_passed = 0;

    difftest_commit_queue #(
        .DATA_W   (c_DATA_W),
        .CHANNELS (c_CH),
        .DEPTH    (c_DEPTH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .commit_debug_pc (commit_debug_pc),
        .commit_flags    (commit_flags),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_debug_pc    (out_debug_pc),
        .out_flags       (out_flags),
        .halted          (halted),
        .overflow        (overflow),
`ifdef DIFFTEST_TIMESTAMP_EN
        .out_timestamp   (out_timestamp),
`endif
        .drop_cnt        (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one commit group for one edge, then idle the lanes.
    task automatic push(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                        input logic [2:0] f0, input logic [2:0] f1);
        commit_valid    = v;
        commit_pc       = {pc1, pc0};
        commit_debug_pc = {pc1 + 64'h1000, pc0 + 64'h1000};
        commit_flags    = {f1, f0};
        tick();
        commit_valid    = '0;
        commit_flags    = '0;
    endtask

    logic [63:0] exp_seq [7];

    initial begin
        reset           = 1'b0;
        commit_valid    = '0;
        commit_pc       = '0;
        commit_debug_pc = '0;
        commit_flags    = '0;
        out_ready       = 1'b0;

        // ---------------- reset state ----------------
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);
        check("rst_drop_cnt",  64'(drop_cnt),  64'd0);
        check("rst_halted",    64'(halted),    64'd0);
        tick();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // ---------------- ordering ----------------
        push(2'b11, 64'hA0, 64'hA1, 3'b000, 3'b000);
        push(2'b10, 64'hDEAD, 64'hB1, 3'b000, 3'b000);
        check("ord_count", 64'(dut.w_count), 64'd3);
        check("ord_pc0",  out_pc,       64'hA0);
        check("ord_dpc0", out_debug_pc, 64'h10A0);
        out_ready = 1'b1;
        tick();
        check("ord_pc1", out_pc, 64'hA1);
        tick();
        check("ord_pc2", out_pc, 64'hB1);
        tick();
        check("ord_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // ---------------- full / overflow ----------------
        for (int g = 0; g < 4; g++) begin
            push(2'b11, 64'h10 + 64'(2*g), 64'h11 + 64'(2*g), 3'b000, 3'b000);
        end
        check("full_count",    64'(dut.w_count), 64'd8);
        check("full_in_ready", 64'(in_ready),    64'd0);
        push(2'b11, 64'h99, 64'h98, 3'b000, 3'b000);
        check("ovf_flag",  64'(overflow),      64'd1);
        check("ovf_drop",  64'(drop_cnt),      64'd2);
        check("ovf_count", 64'(dut.w_count),   64'd8);
        check("ovf_head",  out_pc,             64'h10);
        tick();
        check("idle_drop", 64'(drop_cnt), 64'd2);

        // ---------------- simultaneous push/pop ----------------
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("sim_count6", 64'(dut.w_count), 64'd6);
        check("sim_ready6", 64'(in_ready),    64'd1);
        out_ready = 1'b1;
        push(2'b11, 64'h20, 64'h21, 3'b000, 3'b000);
        check("sim_count7", 64'(dut.w_count), 64'd7);
        check("sim_ready7", 64'(in_ready),    64'd0);
        exp_seq = '{64'h13, 64'h14, 64'h15, 64'h16, 64'h17, 64'h20, 64'h21};
        for (int k = 0; k < 7; k++) begin
            check("sim_drain", out_pc, exp_seq[k]);
            tick();
        end
        check("sim_empty", 64'(out_valid), 64'd0);

        // ---------------- wrap ----------------
        for (int k = 0; k < 20; k++) begin
            push(2'b01, 64'h100 + 64'(k), 64'h0, 3'b000, 3'b000);
            check("wrap_pc", out_pc, 64'h100 + 64'(k));
        end
        tick();
        check("wrap_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // ---------------- asynchronous reset mid-run ----------------
        push(2'b11, 64'h30, 64'h31, 3'b000, 3'b000);
        push(2'b11, 64'h32, 64'h33, 3'b000, 3'b000);
        push(2'b01, 64'h34, 64'h0,  3'b000, 3'b000);
        check("mr_count5", 64'(dut.w_count), 64'd5);
        #2;
        reset = 1'b0;
        #1;
        check("mr_out_valid", 64'(out_valid),     64'd0);
        check("mr_count",     64'(dut.w_count),   64'd0);
        check("mr_overflow",  64'(overflow),      64'd0);
        check("mr_in_ready",  64'(in_ready),      64'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("mr_rel_ready", 64'(in_ready), 64'd1);

        // ---------------- ebreak ----------------
        push(2'b11, 64'h40, 64'h41, 3'b100, 3'b000);
        check("eb_count",    64'(dut.w_count), 64'd1);
        check("eb_in_ready", 64'(in_ready),    64'd0);
        check("eb_pc",       out_pc,           64'h40);
        check("eb_flags",    64'(out_flags),   64'h4);
        check("eb_drop",     64'(drop_cnt),    64'd0);
        check("eb_halt_pre", 64'(halted),      64'd0);
        out_ready = 1'b1;
        tick();
        check("eb_halted",   64'(halted),      64'd1);
        check("eb_empty",    64'(out_valid),   64'd0);
        check("eb_blocked",  64'(in_ready),    64'd0);
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
`default_nettype wire
